// File: rtl/dnn_pkg.sv
// Shared types and width helpers for the two-layer DNN/GNN MAC engine.
package dnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HID_MUL,
        HID_DRAIN,
        AGGR_WAIT,
        OUT_MUL,
        OUT_DRAIN,
        DONE
    } dnn_state_t;

    localparam int RELU_MAX_W = 64;

    function automatic int h_width(input int x_w, input int w_w, input int n_in);
        return x_w + w_w + $clog2(n_in);
    endfunction

    function automatic int o_width(input int h_w, input int w_w, input int n_hid);
        return h_w + w_w + $clog2(n_hid);
    endfunction

    function automatic int groups(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Caller passes the operand's own sign bit, so one function serves any width.
    function automatic logic [RELU_MAX_W-1:0] relu(input logic [RELU_MAX_W-1:0] value,
                                                   input logic neg);
        return neg ? '0 : value;
    endfunction

endpackage

// File: rtl/dnn_mac_engine_if.sv
// Job, activation-export and result handshakes of the DNN MAC engine.
interface dnn_mac_engine_if #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int X_W   = 6,
    parameter int W_W   = 5
);
    import dnn_pkg::*;

    localparam int H_W = h_width(X_W, W_W, N_IN);
    localparam int O_W = o_width(H_W, W_W, N_HID);

    logic                       in_valid;
    logic                       in_ready;
    logic [N_IN*X_W-1:0]        x_in;
    logic [N_IN*N_HID*W_W-1:0]  w_hid;
    logic [N_HID*N_OUT*W_W-1:0] w_out;
    logic                       relu_valid;
    logic [N_HID*H_W-1:0]       relu_out;
    logic                       aggr_valid;
    logic [N_HID*H_W-1:0]       aggr_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_OUT*O_W-1:0]       out_data;

    modport master (
        output in_valid, x_in, w_hid, w_out, aggr_valid, aggr_in, out_ready,
        input  in_ready, relu_valid, relu_out, out_valid, out_data
    );

    modport slave (
        input  in_valid, x_in, w_hid, w_out, aggr_valid, aggr_in, out_ready,
        output in_ready, relu_valid, relu_out, out_valid, out_data
    );

endinterface

// File: rtl/dnn_dot_lane.sv
// One shared dot-product lane: N registered signed products, summed combinationally.
module dnn_dot_lane #(
    parameter int N   = 4,
    parameter int A_W = 13,
    parameter int B_W = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N*A_W-1:0]                 a,
    input  logic [N*B_W-1:0]                 b,
    output logic signed [A_W+B_W+$clog2(N)-1:0] sum
);

    localparam int P_W = A_W + B_W;
    localparam int S_W = P_W + $clog2(N);

    logic signed [P_W-1:0] prod [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the product bank is reset element by element; an array is not cleared by assigning '0 to its name.
            for (int i = 0; i < N; i++) prod[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                prod[i] <= P_W'($signed(a[i*A_W +: A_W])) * P_W'($signed(b[i*B_W +: B_W]));
        end
    end

    always_comb begin
        // NOTE: blocking '=' lets the running sum chain inside one evaluation; starting from '0 keeps it latch-free.
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + S_W'(prod[i]);
    end

endmodule

// File: rtl/dnn_mac_engine.sv
// Two-layer inference engine: hidden layer, external aggregation, output layer on shared lanes.
module dnn_mac_engine
    import dnn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int LANES = 2,
    parameter int X_W   = 6,
    parameter int W_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    dnn_mac_engine_if.slave bus
);

    localparam int H_W   = h_width(X_W, W_W, N_IN);
    localparam int O_W   = o_width(H_W, W_W, N_HID);
    localparam int G_H   = groups(N_HID, LANES);
    localparam int G_O   = groups(N_OUT, LANES);
    localparam int G_MAX = max2(G_H, G_O);
    localparam int G_CW  = $clog2(G_MAX + 1);
    localparam int N_L   = max2(N_IN, N_HID);
    localparam int A_W   = max2(X_W, H_W);
    localparam int S_W   = A_W + W_W + $clog2(N_L);

    dnn_state_t      state;
    logic [G_CW-1:0] g;
    logic [G_CW-1:0] wr_g;
    logic            in_ready;
    logic            relu_valid;
    logic            out_valid;
    logic            wr_hid;
    logic            wr_out;

    logic signed [X_W-1:0] x_r     [N_IN];
    logic signed [W_W-1:0] w_hid_r [N_IN*N_HID];
    logic signed [W_W-1:0] w_out_r [N_HID*N_OUT];
    logic signed [H_W-1:0] hid     [N_HID];
    logic signed [H_W-1:0] aggr    [N_HID];
    logic signed [O_W-1:0] out_r   [N_OUT];

    logic [N_L*A_W-1:0]    op_a     [LANES];
    logic [N_L*W_W-1:0]    op_b     [LANES];
    logic signed [S_W-1:0] lane_sum [LANES];

    logic accept;
    logic aggr_take;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign aggr_take = (state == AGGR_WAIT) && bus.aggr_valid;

    // Sequencer; the write-back tags lag the multiply cycle by one to meet the product registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            g          <= '0;
            wr_g       <= '0;
            in_ready   <= 1'b1;
            relu_valid <= 1'b0;
            out_valid  <= 1'b0;
            wr_hid     <= 1'b0;
            wr_out     <= 1'b0;
        end else begin
            wr_hid <= (state == HID_MUL);
            wr_out <= (state == OUT_MUL);
            wr_g   <= g;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= HID_MUL;
                        in_ready <= 1'b0;
                        g        <= '0;
                    end
                end
                HID_MUL: begin
                    if (g == G_CW'(G_H - 1)) begin
                        g     <= '0;
                        state <= HID_DRAIN;
                    end else begin
                        g <= g + 1'b1;
                    end
                end
                HID_DRAIN: begin
                    state      <= AGGR_WAIT;
                    relu_valid <= 1'b1;
                end
                AGGR_WAIT: begin
                    if (aggr_take) begin
                        state      <= OUT_MUL;
                        relu_valid <= 1'b0;
                    end
                end
                OUT_MUL: begin
                    if (g == G_CW'(G_O - 1)) begin
                        g     <= '0;
                        state <= OUT_DRAIN;
                    end else begin
                        g <= g + 1'b1;
                    end
                end
                OUT_DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++)        x_r[i]     <= '0;
            for (int j = 0; j < N_IN*N_HID; j++)  w_hid_r[j] <= '0;
            for (int j = 0; j < N_HID*N_OUT; j++) w_out_r[j] <= '0;
            for (int h = 0; h < N_HID; h++) begin
                hid[h]  <= '0;
                aggr[h] <= '0;
            end
            for (int o = 0; o < N_OUT; o++)       out_r[o]   <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N_IN; i++)        x_r[i]     <= bus.x_in[i*X_W +: X_W];
                for (int j = 0; j < N_IN*N_HID; j++)  w_hid_r[j] <= bus.w_hid[j*W_W +: W_W];
                for (int j = 0; j < N_HID*N_OUT; j++) w_out_r[j] <= bus.w_out[j*W_W +: W_W];
            end
            if (aggr_take) begin
                for (int h = 0; h < N_HID; h++) aggr[h] <= bus.aggr_in[h*H_W +: H_W];
            end
            // Only real nodes are enumerated, so a lane past the last node never writes.
            for (int h = 0; h < N_HID; h++)
                if (wr_hid && wr_g == G_CW'(h / LANES)) hid[h] <= lane_sum[h % LANES][H_W-1:0];
            for (int o = 0; o < N_OUT; o++)
                if (wr_out && wr_g == G_CW'(o / LANES)) out_r[o] <= lane_sum[o % LANES][O_W-1:0];
        end
    end

    // Lane l of group g serves node g*LANES+l; inputs sign-extend to the shared lane width.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            op_a[l] = '0;
            op_b[l] = '0;
            for (int gi = 0; gi < G_MAX; gi++) begin
                if (g == G_CW'(gi)) begin
                    if (state == HID_MUL && gi*LANES + l < N_HID) begin
                        for (int i = 0; i < N_IN; i++) begin
                            op_a[l][i*A_W +: A_W] = A_W'(x_r[i]);
                            op_b[l][i*W_W +: W_W] = w_hid_r[(gi*LANES + l)*N_IN + i];
                        end
                    end else if (state == OUT_MUL && gi*LANES + l < N_OUT) begin
                        for (int k = 0; k < N_HID; k++) begin
                            op_a[l][k*A_W +: A_W] = A_W'(aggr[k]);
                            op_b[l][k*W_W +: W_W] = w_out_r[(gi*LANES + l)*N_HID + k];
                        end
                    end
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dnn_dot_lane #(
            .N   (N_L),
            .A_W (A_W),
            .B_W (W_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .a   (op_a[l]),
            .b   (op_b[l]),
            .sum (lane_sum[l])
        );
    end

    assign bus.in_ready   = in_ready;
    assign bus.relu_valid = relu_valid;
    assign bus.out_valid  = out_valid;

    always_comb begin
        bus.relu_out = '0;
        bus.out_data = '0;
        if (relu_valid) begin
            for (int h = 0; h < N_HID; h++)
                bus.relu_out[h*H_W +: H_W] = H_W'(relu(RELU_MAX_W'(hid[h]), hid[h][H_W-1]));
        end
        if (out_valid) begin
            for (int o = 0; o < N_OUT; o++) bus.out_data[o*O_W +: O_W] = out_r[o];
        end
    end

endmodule

// File: doc/dnn_mac_engine.md
# dnn_mac_engine

Parametrised, time-multiplexed two-layer DNN/GNN inference engine. It is the generalised successor of the fixed 4-input / 4-hidden / 2-output multiplier-sharing datapath. It computes a hidden layer on `LANES` shared dot-product lanes and exports ReLU'd hidden activations for external neighbour aggregation. It accepts the aggregated values back, then computes the output layer on the same lanes. Valid/ready handshakes replace the free-running state sequence.

## Interface
- `N_IN`, 4, input features per node
- `N_HID`, 4, hidden nodes
- `N_OUT`, 2, output nodes
- `LANES`, 2, dot-product lanes, 1..max(N_HID,N_OUT)
- `X_W`, 6, signed input width
- `W_W`, 5, signed weight width
- derived `H_W` = X_W+W_W+$clog2(N_IN) (13); `O_W` = H_W+W_W+$clog2(N_HID) (20); `G_H`=ceil(N_HID/LANES); `G_O`=ceil(N_OUT/LANES)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid` in 1 / `in_ready` out 1: job handshake
- `x_in`  in  N_IN*X_W  signed features, element i at [i*X_W +: X_W]
- `w_hid`  in  N_IN*N_HID*W_W  weight (i→h) at index h*N_IN+i
- `w_out`  in  N_HID*N_OUT*W_W  weight (h→o) at index o*N_HID+h
- `relu_valid`  out  1  hidden activations valid
- `relu_out`  out  N_HID*H_W  ReLU'd hidden values
- `aggr_valid`  in  1  aggregated values present (single-cycle accept)
- `aggr_in`  in  N_HID*H_W  signed aggregated hidden values
- `out_valid` out 1 / `out_ready` in 1: result handshake
- `out_data`  out  N_OUT*O_W  signed outputs

## Operation
- FSM states: IDLE → HID_MUL → HID_DRAIN → AGGR_WAIT → OUT_MUL → OUT_DRAIN → DONE → IDLE. Typedef is `dnn_state_t`.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, register `x_in`, `w_hid` and `w_out` (all weights captured at accept) and go to HID_MUL.
- HID_MUL: stays G_H cycles with group counter g. Lane l computes the dot product for node h=g*LANES+l. Products are registered and the sum is written to `hid[h]` one cycle later. When h≥N_HID, the lane is idle and its write is suppressed.
- HID_DRAIN: 1 cycle; the last group's sums are written.
- AGGR_WAIT: `relu_valid`=1 and `relu_out[h]` = hid[h] if hid[h][H_W-1]==0, else 0. The sign test is on bit H_W-1. On `aggr_valid`, register `aggr_in` and go to OUT_MUL. `aggr_valid` in any other state is ignored.
- OUT_MUL: G_O cycles. The lanes take aggregated values as multiplicands and `w_out` as multipliers. Lane operands are muxed by state; the lane width is sized for H_W×W_W.
- OUT_DRAIN: 1 cycle. DONE: `out_valid`=1 and `out_data` is held stable until `out_ready`, then the FSM returns to IDLE.
- Arithmetic is full-precision signed, with no overflow possible at the derived widths and no saturation or rounding.
- Reset: state IDLE, counters 0, all data registers 0. Every output is 0 except `in_ready`=1 after reset. Reset mid-job aborts it and no `out_valid` follows.

## Timing
- Accept at cycle 0 → HID_MUL cycles 1..G_H, HID_DRAIN at G_H+1, `relu_valid` high from cycle G_H+2 (defaults: cycle 4).
- `aggr_valid` sampled at cycle A → OUT_MUL A+1..A+G_O, OUT_DRAIN A+G_O+1, `out_valid` from A+G_O+2 (defaults: A+3).
- `in_ready` is 0 outside IDLE, so there is no overlap between jobs. Throughput is one job per G_H+G_O+5 cycles minimum (defaults 8), including the IDLE accept cycle.
- `aggr_valid` on the same cycle `relu_valid` first rises is accepted.
- `out_ready` held high in DONE gives a 1-cycle `out_valid` pulse. `in_valid` in that IDLE cycle is accepted immediately.
- `out_data` and `relu_out` are zero whenever their valid is low.

## Structure
- Package `dnn_pkg` holds `dnn_state_t`, width functions (H_W, O_W, group counts), and the ReLU function.
- Sub-module `dnn_dot_lane`: N-term signed multiply with product registers and a combinational adder tree. Parameters are N, A_W and B_W. It is instantiated LANES times with N=max(N_IN,N_HID), and unused terms are zero-padded.
- Top holds the FSM, group counter, operand muxes, and the hidden, aggregated and output register banks.

## Test plan
- Defaults, x=[1,2,3,4], all w_hid=1 → relu_out all 10 at cycle 4. Then aggr_in all 10 and w_out all 2 → out_data [80,80] at A+3.
- x=[1,0,0,0], w_hid(0→0)=-3, others 0 → hid0=-3, relu_out[0]=0, others 0. Also verify sign detection at bit 12.
- Extremes: x all -32, w_hid all -16 → hidden 2048. Then aggr all 2048, w_out all -16 → out -131072, checked with no wrap.
- Hold out_ready=0 for 5 cycles → out_valid and out_data stable. in_valid during that time → in_ready stays 0 and the job is not accepted.
- Assert rst in HID_MUL and in AGGR_WAIT → all outputs 0 and in_ready=1 on the next cycle, with no out_valid. A subsequent job completes correctly.
- N_HID=5, LANES=2 (G_H=3) with random vectors against a reference model → correct results, idle lane writes nothing, and relu_valid appears at cycle 5.
